// File: rtl/nios2_dbg_pkg.sv
// Shared types and JTAG data-word field positions for the Nios II debug
// on-chip memory controller.
package nios2_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JRD,
        S_JRD_CAP,
        S_JWR,
        S_CRD,
        S_CRD_CAP,
        S_CWR,
        S_C_ACK
    } state_t;

    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_dbg_ocimem_ctrl_if.sv
// CPU-side Avalon-MM debug slave bus into the OCI RAM controller.
interface nios2_dbg_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport slave (
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest
    );

    modport master (
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest
    );

endinterface

// File: rtl/nios2_dbg_ociram.sv
// Single-port DEPTH x 32 debug RAM with per-byte write enables and a
// registered read port (one cycle of latency, read-before-write).
module nios2_dbg_ociram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/nios2_dbg_ocimem_ctrl.sv
// OCI RAM controller: serves JTAG debug reads/writes and CPU Avalon accesses
// through one arbitrating FSM. Define OCIMEM_DEBUGACCESS_EN to block CPU
// writes that lack debugaccess.
module nios2_dbg_ocimem_ctrl
    import nios2_dbg_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [37:0]            jdo,
    input  logic                   take_action_ocimem_a,
    input  logic                   take_action_ocimem_b,
    input  logic                   take_no_action_ocimem_a,
    nios2_dbg_ocimem_ctrl_if.slave bus,
    output logic [31:0]            MonDReg,
    output logic                   jtag_busy
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] mon_areg;
    logic [31:0]       mon_wdata;
    logic              jrd_pend, jwr_pend;
    logic [31:0]       rdata_q;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;
    logic              cpu_wr_en;
    logic              unused;

`ifdef OCIMEM_DEBUGACCESS_EN
    assign cpu_wr_en = bus.debugaccess;
    assign unused    = ^{jdo[37:35], jdo[2:0]};
`else
    assign cpu_wr_en = 1'b1;
    assign unused    = ^{jdo[37:35], jdo[2:0], bus.debugaccess};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        ram_addr   = mon_areg;
        ram_we     = 1'b0;
        ram_be     = 4'hF;
        ram_wdata  = mon_wdata;
        case (state)
            S_IDLE: begin
                if (jwr_pend)       next_state = S_JWR;
                else if (jrd_pend)  next_state = S_JRD;
                else if (bus.write) next_state = S_CWR;
                else if (bus.read)  next_state = S_CRD;
            end
            S_JRD:     next_state = S_JRD_CAP;
            S_JRD_CAP: next_state = S_IDLE;
            S_JWR: begin
                ram_we     = 1'b1;
                next_state = S_IDLE;
            end
            S_CRD: begin
                ram_addr   = bus.address;
                next_state = S_CRD_CAP;
            end
            S_CRD_CAP: next_state = S_C_ACK;
            S_CWR: begin
                ram_addr   = bus.address;
                ram_we     = cpu_wr_en;
                ram_be     = bus.byteenable;
                ram_wdata  = bus.writedata;
                next_state = S_C_ACK;
            end
            S_C_ACK:   next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments; a later JTAG pulse deliberately overrides an FSM clear/increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_areg  <= '0;
            mon_wdata <= '0;
            jrd_pend  <= 1'b0;
            jwr_pend  <= 1'b0;
            MonDReg   <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == S_JRD) jrd_pend <= 1'b0;
            if (state == S_JWR) begin
                jwr_pend <= 1'b0;
                mon_areg <= mon_areg + 1'b1;
            end
            if (state == S_JRD_CAP) MonDReg <= ram_q;
            if (state == S_CRD_CAP) rdata_q <= ram_q;

            if (take_action_ocimem_a) begin
                mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_RD_BIT]) jrd_pend <= 1'b1;
            end else if (take_action_ocimem_b) begin
                mon_wdata <= jdo[JDO_WDATA_LSB +: 32];
                jwr_pend  <= 1'b1;
            end else if (take_no_action_ocimem_a) begin
                mon_areg <= mon_areg + 1'b1;
                jrd_pend <= 1'b1;
            end
        end
    end

    assign jtag_busy       = jrd_pend | jwr_pend | (state == S_JRD) | (state == S_JWR);
    assign bus.waitrequest = (state != S_C_ACK);
    assign bus.readdata    = rdata_q;

    nios2_dbg_ociram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_nios2_dbg_ocimem_ctrl.sv
// Directed scoreboard bench for nios2_dbg_ocimem_ctrl: JTAG and CPU paths,
// address wrap, contention, mid-operation reset and the debugaccess option.
module tb_nios2_dbg_ocimem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int LIMIT  = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
    logic [31:0] MonDReg;
    logic        jtag_busy;

    nios2_dbg_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    nios2_dbg_ocimem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .bus                     (bus),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_pass   = 0;
    logic [31:0]       model [DEPTH];
    logic [ADDR_W-1:0] exp_areg = '0;
    logic [31:0]       exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [37:0] jdo_a(input logic [ADDR_W-1:0] addr, input logic rd);
        logic [37:0] j;
        j = '0;
        j[34] = rd;
        j[17 +: ADDR_W] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[3 +: 32] = data;
        return j;
    endfunction

    task automatic wait_jtag_idle(input string tag);
        int n;
        n = 0;
        while (jtag_busy && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_jtag_idle"}, jtag_busy, 1'b0);
    endtask

    task automatic jtag_rd_result(input string tag);
        wait_jtag_idle(tag);
        tick();
        check({tag, "_MonDReg"}, MonDReg, exp_q.pop_front());
    endtask

    task automatic jtag_a(input string tag, input logic [ADDR_W-1:0] addr, input logic rd);
        jdo = jdo_a(addr, rd);
        take_a = 1'b1;
        exp_areg = addr;
        if (rd) exp_q.push_back(model[addr]);
        tick();
        take_a = 1'b0;
        if (rd) jtag_rd_result(tag);
        else    wait_jtag_idle(tag);
    endtask

    task automatic jtag_b(input string tag, input logic [31:0] data);
        jdo = jdo_b(data);
        take_b = 1'b1;
        model[exp_areg] = data;
        exp_areg = exp_areg + 1'b1;
        tick();
        take_b = 1'b0;
        wait_jtag_idle(tag);
    endtask

    task automatic jtag_na(input string tag);
        take_na = 1'b1;
        exp_areg = exp_areg + 1'b1;
        exp_q.push_back(model[exp_areg]);
        tick();
        take_na = 1'b0;
        jtag_rd_result(tag);
    endtask

    task automatic wait_ack(input string tag, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.waitrequest && lat < LIMIT);
        check({tag, "_ack"}, bus.waitrequest, 1'b0);
    endtask

    task automatic cpu_write(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input logic [3:0] be, input logic da);
        int  lat;
        bit  lands;
        lands = 1'b1;
`ifdef OCIMEM_DEBUGACCESS_EN
        lands = da;
`endif
        if (lands) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
            end
        end
        bus.address = addr;
        bus.writedata = data;
        bus.byteenable = be;
        bus.debugaccess = da;
        bus.write = 1'b1;
        wait_ack(tag, lat);
        bus.write = 1'b0;
        tick();
        check({tag, "_wr_one_cycle"}, bus.waitrequest, 1'b1);
    endtask

    task automatic cpu_read(input string tag, input logic [ADDR_W-1:0] addr, input bit chk_lat);
        int lat;
        exp_q.push_back(model[addr]);
        bus.address = addr;
        bus.read = 1'b1;
        wait_ack(tag, lat);
        check({tag, "_readdata"}, bus.readdata, exp_q.pop_front());
        if (chk_lat) check({tag, "_latency"}, lat, 3);
        bus.read = 1'b0;
        tick();
        check({tag, "_wr_one_cycle"}, bus.waitrequest, 1'b1);
    endtask

    initial begin
        int lat;
        bus.address = '0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.byteenable = '0;
        bus.debugaccess = 1'b1;

        tick();
        tick();
        check("rst_waitrequest", bus.waitrequest, 1'b1);
        check("rst_jtag_busy", jtag_busy, 1'b0);
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // JTAG write then read back
        jtag_a("t1_addr", 8'd5, 1'b0);
        jtag_b("t1_wr", 32'hDEADBEEF);
        jtag_a("t1_rd", 8'd5, 1'b1);
        check("t1_MonAReg", dut.mon_areg, exp_areg);

        // Streaming read across the DEPTH-1 -> 0 wrap
        jtag_a("t2_addr", 8'd255, 1'b0);
        jtag_b("t2_wr255", 32'h11);
        jtag_b("t2_wr0", 32'h22);
        jtag_a("t2_rd255", 8'd255, 1'b1);
        jtag_na("t2_rd0");
        check("t2_MonAReg_wrap", dut.mon_areg, exp_areg);

        // CPU byte-enabled write, then read with latency check
        cpu_write("t3_clr", 8'd3, 32'h0, 4'hF, 1'b1);
        cpu_write("t3_wr", 8'd3, 32'hA5A5A5A5, 4'b0011, 1'b1);
        cpu_read("t3_rd", 8'd3, 1'b1);

        // JTAG write arriving while a CPU read is in CRD
        jtag_a("t4_addr", 8'd9, 1'b0);
        exp_q.push_back(model[3]);
        bus.address = 8'd3;
        bus.read = 1'b1;
        tick();
        jdo = jdo_b(32'hCAFEF00D);
        take_b = 1'b1;
        model[exp_areg] = 32'hCAFEF00D;
        exp_areg = exp_areg + 1'b1;
        tick();
        take_b = 1'b0;
        check("t4_busy_pending", jtag_busy, 1'b1);
        wait_ack("t4_cpu", lat);
        check("t4_readdata", bus.readdata, exp_q.pop_front());
        check("t4_busy_at_ack", jtag_busy, 1'b1);
        bus.read = 1'b0;
        tick();
        check("t4_wr_one_cycle", bus.waitrequest, 1'b1);
        check("t4_busy_before_jwr", jtag_busy, 1'b1);
        wait_jtag_idle("t4_jwr");
        check("t4_MonAReg_inc", dut.mon_areg, exp_areg);
        jtag_a("t4_rd", 8'd9, 1'b1);

        // Reset asserted in CRD_CAP with a JTAG read pending
        bus.address = 8'd3;
        bus.read = 1'b1;
        tick();
        jdo = jdo_a(8'd3, 1'b1);
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        check("t5_busy_before_rst", jtag_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t5_waitrequest", bus.waitrequest, 1'b1);
        check("t5_jtag_busy", jtag_busy, 1'b0);
        check("t5_MonDReg", MonDReg, 32'h0);
        check("t5_readdata", bus.readdata, 32'h0);
        bus.read = 1'b0;
        exp_areg = '0;
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_MonAReg_rst", dut.mon_areg, exp_areg);
        cpu_read("t5_rd", 8'd3, 1'b1);

        // CPU write without debugaccess
        cpu_write("t6_prior", 8'd7, 32'h77777777, 4'hF, 1'b1);
        cpu_write("t6_nodbg", 8'd7, 32'h00001234, 4'hF, 1'b0);
        cpu_read("t6_rd", 8'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
